// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - register map, bit indices and TX FSM states for mmio_uart_ctrl
package mmio_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_FULL     = 2;
  localparam int ST_RX_EMPTY    = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_TX_BUSY     = 5;
  localparam int ST_TX_OVERFLOW = 6;
  localparam int ST_BITS        = 7;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_RX_IRQ_EN = 2;
  localparam int CTRL_TX_IRQ_EN = 3;

  localparam logic [3:0] CTRL_RESET = 4'b0011;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO; a push while full succeeds if a pop happens the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer separates the full and empty cases when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - CPU-bus register block bridging DATA/STATUS/BAUD/CTRL to a UART core
module mmio_uart_ctrl
  import mmio_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] baud_tick_max,
  output logic        irq
);

  tx_state_t state_q;
  tx_state_t state_d;

  logic [15:0] baud_q;
  logic [3:0]  ctrl_q;
  logic        rx_overrun;
  logic        tx_overflow;

  logic        in_range;
  logic [1:0]  reg_idx;
  logic        wr_acc;
  logic        rd_acc;
  logic        rd_hit;

  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic [7:0]  tx_dout;

  logic        rx_push;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_dout;

  logic        rx_ovr_set;
  logic        rx_ovr_clr;
  logic        tx_ovf_set;
  logic        tx_ovf_clr;
  logic        irq_d;

  logic [ST_BITS-1:0] status_bits;
  logic [31:0]        rd_mux;
  logic               bits_unused;

  assign in_range = (address[15:4] == 12'd0);
  assign reg_idx  = address[3:2];
  assign bits_unused = ^{address[1:0], data_in[31:16]};

  // A write wins over a simultaneous read; out-of-range reads still return zero.
  assign wr_acc = sel & wr_en & in_range;
  assign rd_acc = sel & rd_en & ~wr_en;
  assign rd_hit = rd_acc & in_range;

  assign tx_push = wr_acc & (reg_idx == REG_DATA);
  assign tx_pop  = (state_q == TX_IDLE) & ~tx_empty & ctrl_q[CTRL_TX_EN] & ~tx_busy;
  assign rx_pop  = rd_hit & (reg_idx == REG_DATA) & ~rx_empty;
  assign rx_push = rx_valid & ctrl_q[CTRL_RX_EN];

  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
  assign rx_ovr_clr = wr_acc & (reg_idx == REG_STATUS) & data_in[ST_RX_OVERRUN];
  assign tx_ovf_clr = wr_acc & (reg_idx == REG_STATUS) & data_in[ST_TX_OVERFLOW];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (data_in[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    status_bits                 = '0;
    status_bits[ST_TX_FULL]     = tx_full;
    status_bits[ST_TX_EMPTY]    = tx_empty;
    status_bits[ST_RX_FULL]     = rx_full;
    status_bits[ST_RX_EMPTY]    = rx_empty;
    status_bits[ST_RX_OVERRUN]  = rx_overrun;
    status_bits[ST_TX_BUSY]     = tx_busy;
    status_bits[ST_TX_OVERFLOW] = tx_overflow;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_idx)
      REG_DATA:   rd_mux = rx_empty ? 32'd0 : {24'd0, rx_dout};
      REG_STATUS: rd_mux = {{(32-ST_BITS){1'b0}}, status_bits};
      REG_BAUD:   rd_mux = {16'd0, baud_q};
      REG_CTRL:   rd_mux = {28'd0, ctrl_q};
      default:    rd_mux = 32'd0;
    endcase
  end

  assign irq_d = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty)
               | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty & (state_q == TX_IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= 32'd0;
      baud_q      <= BAUD_DEFAULT;
      ctrl_q      <= CTRL_RESET;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      tx_data     <= 8'd0;
      irq         <= 1'b0;
    end else begin
      if (rd_acc) data_out <= rd_hit ? rd_mux : 32'd0;
      if (wr_acc && reg_idx == REG_BAUD) baud_q <= data_in[15:0];
      if (wr_acc && reg_idx == REG_CTRL) ctrl_q <= data_in[3:0];
      // Sticky flags: a new event in the clearing cycle keeps the flag set.
      if (rx_ovr_set)      rx_overrun <= 1'b1;
      else if (rx_ovr_clr) rx_overrun <= 1'b0;
      if (tx_ovf_set)      tx_overflow <= 1'b1;
      else if (tx_ovf_clr) tx_overflow <= 1'b0;
      if (tx_pop) tx_data <= tx_dout;
      irq <= irq_d;
    end
  end

  assign baud_tick_max = baud_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    case (state_q)
      TX_IDLE:      if (tx_pop) state_d = TX_START;
      TX_START: begin
        tx_start = 1'b1;
        state_d  = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (tx_busy) state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
- Memory-mapped peripheral responder for the CPU data bus, decoded in the 0x0003_xxxx region (mmio_data_out source).
- Receives CPU reads and writes and bridges them to the UART core through an 8-bit TX FIFO and an 8-bit RX FIFO.
- Exposes status, baud divisor and control registers, and drives the UART's tx_start/tx_data/baud_tick_max handshake.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2.
- BAUD_DEFAULT, 16'd434, reset value of the BAUD register (50 MHz / 115200).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- sel  in  1  region select (address_bus[31:16]==16'h0003).
- rd_en  in  1  CPU read strobe.
- wr_en  in  1  CPU write strobe.
- address  in  16  byte offset; only [3:2] decoded, [15:4] must be 0.
- data_in  in  32  CPU write data.
- data_out  out  32  read data, registered.
- tx_start  out  1  one-cycle start pulse to the UART transmitter.
- tx_data  out  8  byte to transmit, held stable until the next start.
- tx_busy  in  1  UART transmitter busy.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- baud_tick_max  out  16  BAUD register value.
- irq  out  1  level interrupt.

Behaviour:
- Reset state: data_out=0, tx_start=0, tx_data=0, baud_tick_max=BAUD_DEFAULT, irq=0.
  - Both FIFOs empty, sticky flags clear, CTRL=4'b0011, TX FSM in IDLE.
- An access occurs only when sel=1. If rd_en and wr_en are both high, the write executes and the read is ignored; data_out holds its value.
- Read latency is 1 cycle: data_out updates on the clock edge after rd_en&sel. data_out holds otherwise.
- Offset 0x0 DATA:
  - Write pushes data_in[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set.
  - Read pops the RX FIFO and returns {24'b0, byte}. If the FIFO is empty, the read returns 0 with no pop.
- Offset 0x4 STATUS (read-only except W1C):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
  - bit4 rx_overrun (sticky), bit5 tx_busy (live), bit6 tx_overflow (sticky).
  - A write with bit4 or bit6 set clears the corresponding flag. If a set event and a clear hit the same cycle, set wins.
- Offset 0x8 BAUD: RW, [15:0]; upper bits read 0. The new value appears on baud_tick_max the cycle after the write.
- Offset 0xC CTRL: RW, [3:0].
  - bit0 tx_en, bit1 rx_en, bit2 rx_irq_en, bit3 tx_irq_en.
- Offsets outside 0x0..0xC (address[15:4]≠0): reads return 0, writes are ignored.
- RX path:
  - When rx_valid & rx_en, rx_data is pushed into the RX FIFO.
  - If the FIFO is full, the byte is dropped and rx_overrun is set.
  - A simultaneous push and CPU pop both take effect and the count is unchanged; this includes the full case, where the push succeeds.
  - rx_valid is ignored when rx_en=0.
- TX FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE→START when TX FIFO not empty & tx_en & !tx_busy. The FIFO is popped on this edge and tx_data is loaded.
  - START: tx_start=1 for exactly one cycle, then →WAIT_BUSY.
  - WAIT_BUSY→WAIT_DONE when tx_busy=1.
  - WAIT_DONE→IDLE when tx_busy=0.
  - Clearing tx_en mid-byte finishes the current byte, then the FSM stays in IDLE.
  - A CPU push in the same cycle as an FSM pop is allowed; the count is unchanged.
- irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & FSM==IDLE). irq is registered, with 1 cycle of lag.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full/empty are derived from pointer MSB comparison.
- rst asserted mid-transfer aborts immediately to the reset state; the UART core is reset by the same rst.

Decomposition:
- Package mmio_uart_pkg holds:
  - Register offset constants (REG_DATA=2'd0, REG_STATUS=2'd1, REG_BAUD=2'd2, REG_CTRL=2'd3).
  - STATUS/CTRL bit index constants.
  - TX FSM state typedef.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH), instantiated twice.
  - Ports: push, pop, din, dout, full, empty.
  - dout is first-word-fall-through.

Test Plan:
- Reset, then read 0x4 → data_out=32'h0000_000A (tx_empty, rx_empty). Read 0x8 → 434. irq=0, tx_start=0.
- Write 0x0 = 8'h55 and 8'hA3 with a UART model whose tx_busy rises 1 cycle after start and stays high 10 cycles:
  - Two tx_start pulses, tx_data 0x55 then 0xA3.
  - Second pulse not before tx_busy falls; STATUS bit1 returns to 1.
- Pulse rx_valid with 0x11, 0x22, 0x33, then read 0x0 ×4 → 0x11, 0x22, 0x33, 0x00; STATUS bit3=1 afterwards.
- With FIFO_DEPTH=8, push 9 RX bytes:
  - STATUS bit2=1, bit4=1; the 9th byte is lost.
  - Write 0x4=32'h10 clears bit4. A simultaneous rx_valid and DATA read when full keeps bit2=1 and leaves overrun clear.
- Set CTRL=4'b0111, inject rx byte → irq=1 within 2 cycles; read DATA → irq=0. Write BAUD=16'd27 → baud_tick_max=27 the next cycle.
- With tx_en=0, push 3 bytes → no tx_start. Assert rst asynchronously mid-WAIT_DONE → all outputs return to reset values without waiting for a clock edge.
